// File: rtl/uart_stress_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_stress_pkg
// Description : Shared definitions for the UART stress checker: operating
//               mode encodings and a saturating-increment helper used by all
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_stress_pkg;

    // Operating mode as seen on the MODE pins; 2'b11 is folded onto CHECK.
    typedef enum logic [1:0] {
        ECHO  = 2'b00,
        GEN   = 2'b01,
        CHECK = 2'b10
    } mode_e;

    // Increment that sticks at i_max instead of wrapping. Callers zero-extend
    // their narrower counters to 32 bits and pass their own all-ones maximum.
    function automatic logic [31:0] sat_inc(input logic [31:0] i_val,
                                            input logic [31:0] i_max);
        return (i_val == i_max) ? i_val : i_val + 32'd1;
    endfunction

endpackage : uart_stress_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Single-clock byte FIFO with synchronous flush and
//               asynchronous active-high reset. A push into a full FIFO is
//               accepted when a pop happens in the same cycle.
// Ports       : clk, rst        - clock, async active-high reset
//               i_flush         - empty the FIFO (overrides push/pop)
//               i_push, i_din   - write request and data
//               i_pop           - read request (head advances)
//               o_dout          - current head byte
//               o_full, o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int C_AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [C_AW:0] r_wr_ptr;
    logic [C_AW:0] r_rd_ptr;
    logic [7:0]    r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                      (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[C_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= i_din;
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/uart_stress_checker.sv
`default_nettype none
// ============================================================================
// Module      : uart_stress_checker
// Description : UART link stress checker. Every received byte is checked
//               against an incrementing sequence and tallied; the transmit
//               side either echoes received bytes through a FIFO, generates
//               an incrementing pattern, or stays idle.
// Ports       : SCLK, RESET     - clock, async active-high reset
//               CLEAR           - sync clear of stats, checker, GEN and FIFO
//               MODE            - 00 echo, 01 generate, 1x check-only
//               RX_VALID/RX_DATA- received byte strobe and data
//               TX_READY        - transmitter accepts TX_DATA this cycle
//               TX_VALID/TX_DATA- byte offered to the transmitter
//               TOTAL/GOOD/BAD/DROPPED - saturating statistics
//               SYNC            - checker locked onto the sequence
// Revision    : 1.0 - initial release
// ============================================================================
module uart_stress_checker
    import uart_stress_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int SYNC_N     = 4
) (
    input  logic             SCLK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic [1:0]       MODE,
    input  logic             RX_VALID,
    input  logic [7:0]       RX_DATA,
    input  logic             TX_READY,
    output logic             TX_VALID,
    output logic [7:0]       TX_DATA,
    output logic [CNT_W-1:0] TOTAL,
    output logic [CNT_W-1:0] GOOD,
    output logic [CNT_W-1:0] BAD,
    output logic [CNT_W-1:0] DROPPED,
    output logic             SYNC
);

    localparam int                 C_RUN_W   = $clog2(SYNC_N + 1);
    localparam logic [C_RUN_W-1:0] C_RUN_MAX = C_RUN_W'(SYNC_N);
    localparam logic [CNT_W-1:0]   C_CNT_ONES = '1;
    localparam logic [31:0]        C_CNT_MAX = 32'(C_CNT_ONES);

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] i_v);
        logic [31:0] v_t;
        v_t = sat_inc(32'(i_v), C_CNT_MAX);
        return v_t[CNT_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Mode tracking
    // ------------------------------------------------------------------
    mode_e w_mode;
    mode_e r_mode_q;
    logic  r_mode_vld;   // low straight after reset: first cycle only latches
    logic  w_mode_chg;

    always_comb begin
        w_mode = CHECK;
        case (MODE)
            2'b00:   w_mode = ECHO;
            2'b01:   w_mode = GEN;
            default: w_mode = CHECK;
        endcase
    end

    // A mode change is seen combinationally; the edge that ends this cycle
    // flushes the FIFO and zeroes GEN. TX is held off during this cycle so no
    // byte from the old mode's state is handed out under the new mode.
    assign w_mode_chg = r_mode_vld && (w_mode != r_mode_q);

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            r_mode_q   <= CHECK;
            r_mode_vld <= 1'b0;
        end else begin
            r_mode_q   <= w_mode;
            r_mode_vld <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    logic [7:0] r_gen;
    logic [7:0] w_fifo_dout;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_xfer;
    logic       w_push_req;
    logic       w_pop;
    logic       w_flush;
    logic       w_drop;

    assign TX_VALID = r_mode_vld && !w_mode_chg &&
                      ((w_mode == GEN) || ((w_mode == ECHO) && !w_fifo_empty));
    assign TX_DATA  = (w_mode == GEN) ? r_gen : w_fifo_dout;
    assign w_xfer   = TX_VALID && TX_READY;

    assign w_flush    = CLEAR || w_mode_chg;
    assign w_push_req = RX_VALID && (w_mode == ECHO) && !w_flush;
    assign w_pop      = w_xfer && (w_mode == ECHO) && !w_flush;
    // Full FIFO still takes the byte when the head leaves in the same cycle.
    assign w_drop     = w_push_req && w_fifo_full && !w_pop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (SCLK),
        .rst     (RESET),
        .i_flush (w_flush),
        .i_push  (w_push_req),
        .i_din   (RX_DATA),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            r_gen <= 8'd0;
        end else if (w_flush) begin
            r_gen <= 8'd0;
        end else if (w_xfer && (w_mode == GEN)) begin
            r_gen <= r_gen + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequence checker and statistics (active in every mode)
    // ------------------------------------------------------------------
    logic [7:0]         r_exp;
    logic [C_RUN_W-1:0] r_run;
    logic [C_RUN_W-1:0] w_run_nxt;
    logic               r_sync;
    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_good;
    logic [CNT_W-1:0]   r_bad;
    logic [CNT_W-1:0]   r_dropped;

    // The run length parks at SYNC_N so SYNC stays up through long matches.
    assign w_run_nxt = (r_run == C_RUN_MAX) ? r_run : r_run + 1'b1;

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            r_exp     <= 8'd0;
            r_run     <= '0;
            r_sync    <= 1'b0;
            r_total   <= '0;
            r_good    <= '0;
            r_bad     <= '0;
            r_dropped <= '0;
        end else if (CLEAR) begin
            r_exp     <= 8'd0;
            r_run     <= '0;
            r_sync    <= 1'b0;
            r_total   <= '0;
            r_good    <= '0;
            r_bad     <= '0;
            r_dropped <= '0;
        end else begin
            if (RX_VALID) begin
                r_total <= cnt_inc(r_total);
                if (RX_DATA == r_exp) begin
                    r_good <= cnt_inc(r_good);
                    r_exp  <= r_exp + 8'd1;
                    r_run  <= w_run_nxt;
                    r_sync <= (w_run_nxt == C_RUN_MAX);
                end else begin
                    // Resynchronise on the received value.
                    r_bad  <= cnt_inc(r_bad);
                    r_exp  <= RX_DATA + 8'd1;
                    r_run  <= '0;
                    r_sync <= 1'b0;
                end
            end
            if (w_drop) begin
                r_dropped <= cnt_inc(r_dropped);
            end
        end
    end

    assign TOTAL   = r_total;
    assign GOOD    = r_good;
    assign BAD     = r_bad;
    assign DROPPED = r_dropped;
    assign SYNC    = r_sync;

endmodule : uart_stress_checker
`default_nettype wire
